// File: rtl/imem_loader.sv
// Framed instruction-memory loader: MAGIC, LEN_H, LEN_L, LEN data words, CSUM.
// Holds the CPU in reset while a frame is in flight or after a rejected frame.
//   state | meaning
//   IDLE  | waiting for MAGIC, other words dropped
//   LEN_H | expecting length high byte
//   LEN_L | expecting length low byte
//   DATA  | writing payload words to memory
//   CHK   | expecting checksum word
//   DONE  | frame loaded and verified
//   ERROR | frame rejected
module imem_loader #(
    parameter int                   WORD_SIZE = 8,
    parameter int                   ROM_SIZE  = 256,
    parameter int                   ADDR_W    = $clog2(ROM_SIZE),
    parameter logic [WORD_SIZE-1:0] MAGIC     = 'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic                 clear,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 cpu_rst
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN_H = 3'd1,
        S_LEN_L = 3'd2,
        S_DATA  = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [15:0] ROM_LEN = 16'(ROM_SIZE);

    state_t                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   sum_q, sum_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   beat;
    logic [15:0]            len_full;

    assign beat     = rx_valid && rx_ready_q;
    assign len_full = {len_q[15:8], rx_data[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_rst_d   = cpu_rst_q;

        case (state_q)
            S_IDLE: begin
                if (beat && rx_data == MAGIC) begin
                    state_d   = S_LEN_H;
                    busy_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                end
            end
            S_LEN_H: begin
                if (beat) begin
                    len_d   = {rx_data[7:0], len_q[7:0]};
                    state_d = S_LEN_L;
                end
            end
            S_LEN_L: begin
                if (beat) begin
                    len_d = len_full;
                    cnt_d = '0;
                    sum_d = '0;
                    if (len_full > ROM_LEN) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (beat) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = rx_data;
                    cnt_d       = cnt_q + 16'd1;
                    sum_d       = sum_q + rx_data;
                    if (cnt_q + 16'd1 == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (beat) begin
                    busy_d = 1'b0;
                    if (rx_data == sum_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        // memory now holds a partial/bad image, keep the CPU parked
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            S_ERROR: begin
                if (clear) begin
                    state_d   = S_IDLE;
                    error_d   = 1'b0;
                    cpu_rst_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d = !(state_d == S_DONE || state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_q   <= cpu_rst_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, checksum errors, resync, gaps and reset.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       clear = 1'b0;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       error;
    logic       cpu_rst;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];

    imem_loader #(.WORD_SIZE(8), .ROM_SIZE(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .clear     (clear),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_rst   (cpu_rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one word and returns #1 after the edge that transferred it.
    task automatic send(input logic [7:0] d);
        int   n;
        logic r;
        n        = 0;
        rx_data  = d;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            if (r === 1'b1) break;
            n++;
            if (n > 20) begin
                n_err++;
                $error("FAIL send_timeout: observed rx_ready=%0b expected 1", r);
                break;
            end
        end
        #1;
    endtask

    task automatic gap();
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata",    32'(mem_wdata),32'd0);
        chk("rst_flags",    32'({busy, done, error, cpu_rst}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(rx_ready), 32'd1);

        // good 3-word frame, back-to-back
        clr_log();
        send(8'hA5); send(8'h00); send(8'h03);
        chk("t1_busy",    32'(busy),    32'd1);
        chk("t1_cpu_rst", 32'(cpu_rst), 32'd1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h66);
        rx_valid = 1'b0;
        chk("t1_done",    32'(done),    32'd1);
        chk("t1_error",   32'(error),   32'd0);
        chk("t1_cpu_rst_after", 32'(cpu_rst), 32'd0);
        chk("t1_busy_after",    32'(busy),    32'd0);
        @(negedge clk);
        chk("t1_rdy_done", 32'(rx_ready), 32'd0);
        chk("t1_nwr",  32'(wa.size()), 32'd3);
        chk("t1_w0",   32'({wa[0], wd[0]}), 32'h0011);
        chk("t1_w1",   32'({wa[1], wd[1]}), 32'h0122);
        chk("t1_w2",   32'({wa[2], wd[2]}), 32'h0233);
        chk("t1_b2b",  32'(wc[2] - wc[0]),  32'd2);
        chk("t1_addr_hold", 32'(mem_addr), 32'd2);
        pulse_clear();
        chk("t1_clear_done", 32'(done), 32'd0);
        chk("t1_clear_rdy",  32'(rx_ready), 32'd1);

        // bad checksum, then clear while rx_valid is held
        clr_log();
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h67);
        rx_valid = 1'b0;
        chk("t2_error",   32'(error),   32'd1);
        chk("t2_done",    32'(done),    32'd0);
        chk("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t2_rdy",     32'(rx_ready),32'd0);
        chk("t2_nwr",     32'(wa.size()), 32'd3);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        pulse_clear();
        rx_valid = 1'b0;
        chk("t2_clr_error",   32'(error),   32'd0);
        chk("t2_clr_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("t2_clr_rdy",     32'(rx_ready),32'd1);
        chk("t2_clr_busy",    32'(busy),    32'd0);

        // resync garbage, zero-length frame
        clr_log();
        send(8'h00); send(8'hFF);
        chk("t3_resync_busy", 32'(busy), 32'd0);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_nwr",  32'(wa.size()), 32'd0);
        pulse_clear();

        // oversize length
        clr_log();
        send(8'hA5); send(8'h01); send(8'h01);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t4_error",   32'(error), 32'd1);
        chk("t4_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t4_nwr",     32'(wa.size()), 32'd0);
        pulse_clear();

        // gapped frame, sum wraps
        clr_log();
        send(8'hA5); gap(); send(8'h00); gap(); send(8'h04); gap();
        for (int i = 0; i < 4; i++) begin
            send(8'hFF);
            gap();
        end
        send(8'hFC);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_nwr",  32'(wa.size()), 32'd4);
        chk("t5_w0",   32'({wa[0], wd[0]}), 32'h00FF);
        chk("t5_w3",   32'({wa[3], wd[3]}), 32'h03FF);
        chk("t5_gap",  32'(wc[1] - wc[0]),  32'd2);
        pulse_clear();

        // reset mid-frame, then a fresh frame
        clr_log();
        send(8'hA5); send(8'h00); send(8'h03); send(8'h11); send(8'h22);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_rst_flags", 32'({busy, done, error, cpu_rst}), 32'd0);
        chk("t6_rst_we",    32'(mem_we),   32'd0);
        chk("t6_rst_addr",  32'(mem_addr), 32'd0);
        chk("t6_rst_rdy",   32'(rx_ready), 32'd0);
        chk("t6_nwr_pre",   32'(wa.size()), 32'd2);
        clr_log();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h5A); send(8'h3C); send(8'h96);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_nwr",  32'(wa.size()), 32'd2);
        chk("t6_w0",   32'({wa[0], wd[0]}), 32'h005A);
        chk("t6_w1",   32'({wa[1], wd[1]}), 32'h013C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
